dff_exerciser: RTL and testbench

DFF_EXERCISER -- requirements
Module: dff_exerciser

---
 rtl/dff_exerciser.sv | 88 ++++++++
 tb/tb_dff_exerciser.sv | 115 +++++++++++
 2 files changed

// File: rtl/dff_exerciser.sv
// dff_exerciser: sweeps en/d over 8 states to exercise a downstream enabled D flip-flop.
// Define DFF_EXERCISER_CHECK_EN to compile in the q checker and error counter.
module dff_exerciser #(
    parameter int NUM_PASSES = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             q,
    output logic             en,
    output logic             d,
    output logic [2:0]       state,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_count,
    output logic             pass
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fsm_t;
    fsm_t fsm;
    logic [3:0] pcnt;
    logic       dcnt;
    logic [2:0] nxt;
    assign nxt  = state + 3'd1;
    assign busy = fsm == RUN || fsm == DRAIN;
    assign done = fsm == DONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm   <= IDLE;
            en    <= 1'b0;
            d     <= 1'b0;
            state <= 3'd0;
            pcnt  <= 4'd0;
            dcnt  <= 1'b0;
        end else begin
            case (fsm)
                IDLE, DONE: if (start) begin
                    fsm   <= RUN;
                    state <= 3'd1;
                    en    <= 1'b1;
                    d     <= 1'b0;
                    pcnt  <= 4'd0;
                end
                RUN: if (state == 3'd0 && pcnt == 4'(NUM_PASSES - 1)) begin
                    fsm   <= DRAIN;
                    en    <= 1'b0;
                    d     <= 1'b0;
                    dcnt  <= 1'b0;
                end else begin
                    state <= nxt;
                    en    <= nxt[2] ^ nxt[0];
                    d     <= nxt[1];
                    pcnt  <= state == 3'd0 ? pcnt + 4'd1 : pcnt;
                end
                DRAIN: begin
                    dcnt <= 1'b1;
                    fsm  <= dcnt ? DONE : DRAIN;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
`ifdef DFF_EXERCISER_CHECK_EN
    // q_exp tracks what the flip-flop should hold after each edge
    logic q_exp, valid;
    always_ff @(posedge clk) begin
        if (rst) begin
            q_exp     <= 1'b0;
            valid     <= 1'b0;
            err_count <= '0;
        end else if ((fsm == IDLE || fsm == DONE) && start) begin
            valid     <= 1'b0;
            err_count <= '0;
        end else if (busy) begin
            q_exp <= en ? d : q_exp;
            valid <= valid | en;
            if (valid && q != q_exp && err_count != {ERR_W{1'b1}})
                err_count <= err_count + 1'b1;
        end
    end
    assign pass = done && err_count == '0;
`else
    logic unused_q;
    assign unused_q  = q;
    assign err_count = '0;
    assign pass      = done;
`endif
endmodule

// File: tb/tb_dff_exerciser.sv
// tb_dff_exerciser: scoreboard bench; stimulus queues expected outputs, a negedge monitor checks them.
module tb_dff_exerciser;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, q, en, d, busy, done, pass;
    logic [2:0] state;
    logic [7:0] err_count;
    logic       q_ff = 1'b0, tie0 = 1'b0;
    int         errors = 0, checks = 0;

    typedef struct packed {
        logic en, d; logic [2:0] st; logic busy, done, pass; logic [7:0] err; logic ce;
    } exp_t;
    exp_t  exp_q[$];
    string name_q[$];

    // per-step en/d for states 1..7,0 (bit k = step k)
    localparam logic [7:0] EN_T = 8'b00101101;
    localparam logic [7:0] D_T  = 8'b01100110;
`ifdef DFF_EXERCISER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    dff_exerciser #(.NUM_PASSES(2), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .q(q), .en(en), .d(d), .state(state),
        .busy(busy), .done(done), .err_count(err_count), .pass(pass)
    );

    always #5 clk = ~clk;
    assign q = tie0 ? 1'b0 : q_ff;
    always @(posedge clk) if (en) q_ff <= d;

    function automatic exp_t mk(logic e, logic dd, logic [2:0] s, logic b, logic dn, logic p,
                                logic [7:0] er, logic ce);
        exp_t x;
        x = '{en: e, d: dd, st: s, busy: b, done: dn, pass: p, err: er, ce: ce};
        return x;
    endfunction

    function automatic void cmp(string nm, logic [7:0] a, logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            cmp({nm, ".en"}, 8'(en), 8'(e.en));
            cmp({nm, ".d"}, 8'(d), 8'(e.d));
            cmp({nm, ".state"}, 8'(state), 8'(e.st));
            cmp({nm, ".busy"}, 8'(busy), 8'(e.busy));
            cmp({nm, ".done"}, 8'(done), 8'(e.done));
            cmp({nm, ".pass"}, 8'(pass), 8'(e.pass));
            if (e.ce) cmp({nm, ".err"}, err_count, e.err);
        end
    end

    task automatic step(input logic s, input logic r, input exp_t e, input string nm);
        start = s;
        rst   = r;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic run(input logic tie, input logic hold, input string nm);
        logic [7:0] ee;
        tie0 = tie;
        step(1'b1, 1'b0, mk(1, 0, 3'd1, 1, 0, 0, 8'd0, 1), {nm, ".start"});
        for (int i = 1; i < 16; i++) begin
            int k;
            k = i % 8;
            step(hold, 1'b0, mk(EN_T[k], D_T[k], 3'(k + 1), 1, 0, 0, 8'd0, 0), $sformatf("%s.run%0d", nm, i));
        end
        step(hold, 1'b0, mk(0, 0, 3'd0, 1, 0, 0, 8'd0, 0), {nm, ".drain1"});
        step(hold, 1'b0, mk(0, 0, 3'd0, 1, 0, 0, 8'd0, 0), {nm, ".drain2"});
        ee = (CHK && tie) ? 8'd9 : 8'd0;
        step(hold, 1'b0, mk(0, 0, 3'd0, 0, 1, ee == 8'd0, ee, 1), {nm, ".done"});
        step(1'b0, 1'b0, mk(0, 0, 3'd0, 0, 1, ee == 8'd0, ee, 1), {nm, ".done_hold"});
    endtask

    initial begin
        exp_t z;
        z = mk(0, 0, 3'd0, 0, 0, 0, 8'd0, 1);
        step(1'b0, 1'b1, z, "rst0");
        step(1'b0, 1'b1, z, "rst1");
        step(1'b0, 1'b0, z, "idle");
        run(1'b0, 1'b0, "good");
        run(1'b1, 1'b1, "tie0_hold");
        run(1'b0, 1'b0, "restart");
        tie0 = 1'b1;
        step(1'b1, 1'b0, mk(1, 0, 3'd1, 1, 0, 0, 8'd0, 1), "mid.start");
        for (int i = 1; i < 5; i++)
            step(1'b0, 1'b0, mk(EN_T[i], D_T[i], 3'(i + 1), 1, 0, 0, 8'd0, 0), $sformatf("mid.run%0d", i));
        step(1'b1, 1'b1, z, "mid.rst");
        step(1'b0, 1'b0, z, "mid.idle");
        step(1'b1, 1'b0, mk(1, 0, 3'd1, 1, 0, 0, 8'd0, 1), "mid.restart");
        step(1'b0, 1'b1, z, "mid.rst2");
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
